// File: rtl/ram_pkg.sv
// Shared constants and types for the small scratch RAM family.
package ram_pkg;

  localparam int RAM_DATA_WIDTH = 4;
  localparam int RAM_DEPTH      = 16;
  localparam int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH);

  typedef logic [RAM_DATA_WIDTH-1:0] ram_word_t;
  typedef logic [RAM_ADDR_WIDTH-1:0] ram_addr_t;

endpackage : ram_pkg

// File: rtl/ram_16x4.sv
// Single-port synchronous scratch RAM with one shared read/write address.
// The read port is write-first: on a write cycle the new word appears on
// data_out after the same edge. A synchronous reset clears every word and
// the output register, and it wins over a write in the same cycle.
// DEPTH is expected to be a power of two and at least 2. ADDR_WIDTH is
// derived from it, so every address value maps onto a real word.
module ram_16x4
  import ram_pkg::*;
#(
  parameter  int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter  int DEPTH      = RAM_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  // Storage is kept in flops so that reset can clear every word in one cycle.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array and read register update together: reset, else write-first write, else read.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem      <= '{default: '0};
      data_out <= '0;
    end else if (write_enable) begin
      mem[addr] <= data_in;
      data_out  <= data_in;
    end else begin
      data_out <= mem[addr];
    end
  end

endmodule : ram_16x4

// File: tb/tb_ram_16x4.sv
// Directed bench for ram_16x4: a behavioural model tracks the memory and the
// expected read word, and a compare process checks data_out every cycle.
module tb_ram_16x4;
  import ram_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  logic      write_enable = 1'b0;
  ram_addr_t addr = '0;
  ram_word_t data_in = '0;
  ram_word_t data_out;

  ram_word_t model_mem [RAM_DEPTH];
  ram_word_t exp_out;
  bit        armed = 1'b0;
  int        n_vec = 0;
  int        n_miss = 0;
  int        n_cyc = 0;

  ram_16x4 dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .addr         (addr),
    .data_in      (data_in),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus and advance the model to its post-edge state.
  task automatic step(input logic r, input logic we, input ram_addr_t a, input ram_word_t d);
    @(negedge clk);
    rst = r;
    write_enable = we;
    addr = a;
    data_in = d;
    if (r) begin
      for (int i = 0; i < RAM_DEPTH; i++) model_mem[i] = '0;
      exp_out = '0;
    end else if (we) begin
      model_mem[a] = d;
      exp_out = d;
    end else begin
      exp_out = model_mem[a];
    end
    @(posedge clk);
    armed = 1'b1;
  endtask

  // Hand-computed literal, checked just after the edge the last step waited on.
  task automatic expect_lit(input string name, input ram_word_t want);
    #2;
    n_vec++;
    if (data_out !== want) begin
      n_miss++;
      $display("FAIL %s: data_out=%h required=%h at %0t", name, data_out, want, $time);
    end
  endtask

  // Per-cycle comparison of the DUT against the model.
  always @(posedge clk) begin
    #1;
    n_cyc++;
    if (armed) begin
      n_vec++;
      if (data_out !== exp_out) begin
        n_miss++;
        $display("FAIL model_cmp: addr=%h we=%b rst=%b data_out=%h required=%h at %0t",
                 addr, write_enable, rst, data_out, exp_out, $time);
      end
    end
  end

  initial begin
    // Reset held for two cycles, then every address reads back as zero.
    step(1'b1, 1'b0, 4'h0, 4'h0);
    step(1'b1, 1'b1, 4'h6, 4'hF);
    expect_lit("reset_out", 4'h0);
    for (int i = 0; i < RAM_DEPTH; i++) begin
      step(1'b0, 1'b0, ram_addr_t'(i), 4'h0);
      expect_lit("reset_read", 4'h0);
    end

    // Basic write then read.
    step(1'b0, 1'b1, 4'h3, 4'hA);
    expect_lit("write_first_a", 4'hA);
    step(1'b0, 1'b0, 4'h3, 4'h0);
    expect_lit("read_3", 4'hA);

    // Second location and no aliasing.
    step(1'b0, 1'b1, 4'h5, 4'hC);
    step(1'b0, 1'b0, 4'h5, 4'h0);
    expect_lit("read_5", 4'hC);
    step(1'b0, 1'b0, 4'h3, 4'h0);
    expect_lit("read_3_again", 4'hA);

    // Write-first visibility and immediate read-back.
    step(1'b0, 1'b1, 4'h9, 4'h7);
    expect_lit("write_first_9", 4'h7);
    step(1'b0, 1'b0, 4'h9, 4'h0);
    expect_lit("read_9", 4'h7);

    // Same address written twice: last write wins.
    step(1'b0, 1'b1, 4'h9, 4'h1);
    step(1'b0, 1'b1, 4'h9, 4'h2);
    step(1'b0, 1'b0, 4'h9, 4'h0);
    expect_lit("last_write_wins", 4'h2);

    // Full sweep with inverted-address pattern, boundaries included.
    for (int i = 0; i < RAM_DEPTH; i++)
      step(1'b0, 1'b1, ram_addr_t'(i), ram_word_t'(i ^ 4'hF));
    for (int i = 0; i < RAM_DEPTH; i++) begin
      step(1'b0, 1'b0, ram_addr_t'(i), 4'h0);
      expect_lit("sweep_read", ram_word_t'(i ^ 4'hF));
    end

    // Reset beats a simultaneous write; everything reads zero afterwards.
    step(1'b1, 1'b1, 4'h2, 4'h5);
    expect_lit("rst_vs_write", 4'h0);
    step(1'b0, 1'b0, 4'h2, 4'h0);
    expect_lit("read_2_after_rst", 4'h0);
    step(1'b0, 1'b0, 4'hF, 4'h0);
    expect_lit("read_15_after_rst", 4'h0);

    // A few mixed cycles left to the model alone.
    step(1'b0, 1'b1, 4'h0, 4'h8);
    step(1'b0, 1'b0, 4'hF, 4'h0);
    step(1'b0, 1'b1, 4'hF, 4'h6);
    step(1'b0, 1'b0, 4'h0, 4'h0);
    step(1'b0, 1'b0, 4'hF, 4'h0);

    @(negedge clk);
    armed = 1'b0;
    if (n_cyc > 10000) begin
      n_miss++;
      $display("FAIL cycle_budget: cycles=%0d limit=10000", n_cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_ram_16x4
